// File: rtl/mmio_uart_ctrl.sv
// I/O-region MMIO responder: one-entry UART tx/rx buffers plus cycle and retired-instruction counters.
// Load data is registered (1 cycle); a full tx buffer drops stores, a full rx buffer holds off via rx_ready.
module mmio_uart_ctrl #(
  parameter logic [3:0] IO_TAG    = 4'h8,
  parameter int         CNT_WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic        re,
  input  logic        inst_retire,
  output logic [31:0] rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);
  localparam logic [7:0] OFF_STATUS = 8'h00;
  localparam logic [7:0] OFF_RX     = 8'h04;
  localparam logic [7:0] OFF_TX     = 8'h08;
  localparam logic [7:0] OFF_CYCLE  = 8'h10;
  localparam logic [7:0] OFF_INST   = 8'h14;
  localparam logic [7:0] OFF_CLR    = 8'h18;

  logic                 sel;
  logic                 rd_hit;
  logic                 wr_hit;
  logic [7:0]           offset;
  logic [7:0]           tx_buf;
  logic [7:0]           rx_buf;
  logic                 tx_full;
  logic                 rx_full;
  logic [CNT_WIDTH-1:0] cycle_cnt;
  logic [CNT_WIDTH-1:0] inst_cnt;
  logic                 tx_fire;
  logic                 tx_load;
  logic                 rx_load;
  logic                 rx_pop;
  logic                 cnt_clear;
  logic [31:0]          rd_mux;
  logic                 unused_bits;

  assign sel       = (addr[31:28] == IO_TAG);
  assign offset    = addr[7:0];
  assign rd_hit    = sel & re;
  assign wr_hit    = sel & we;
  assign unused_bits = ^{addr[27:8], wdata[31:8]};

  assign tx_valid  = tx_full;
  assign tx_data   = tx_buf;
  assign rx_ready  = ~rx_full;

  // A store landing in the handshake cycle refills the buffer instead of being dropped.
  assign tx_fire   = tx_full & tx_ready;
  assign tx_load   = wr_hit && (offset == OFF_TX) && (!tx_full || tx_fire);
  assign rx_load   = rx_valid & ~rx_full;
  assign rx_pop    = rd_hit && (offset == OFF_RX) && rx_full;
  assign cnt_clear = wr_hit && (offset == OFF_CLR);

  always_comb begin
    rd_mux = '0;
    case (offset)
      OFF_STATUS: rd_mux = {30'b0, rx_full, ~tx_full};
      OFF_RX:     rd_mux = {24'b0, rx_buf};
      OFF_CYCLE:  rd_mux = 32'(cycle_cnt);
      OFF_INST:   rd_mux = 32'(inst_cnt);
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata     <= '0;
      tx_buf    <= '0;
      tx_full   <= 1'b0;
      rx_buf    <= '0;
      rx_full   <= 1'b0;
      cycle_cnt <= '0;
      inst_cnt  <= '0;
    end else begin
      rdata <= rd_hit ? rd_mux : '0;

      if (tx_load) begin
        tx_buf  <= wdata[7:0];
        tx_full <= 1'b1;
      end else if (tx_fire) begin
        tx_full <= 1'b0;
      end

      // rx_load and rx_pop are exclusive: one needs the buffer empty, the other full.
      if (rx_load) begin
        rx_buf  <= rx_data;
        rx_full <= 1'b1;
      end else if (rx_pop) begin
        rx_full <= 1'b0;
      end

      if (cnt_clear) begin
        cycle_cnt <= '0;
        inst_cnt  <= '0;
      end else begin
        cycle_cnt <= cycle_cnt + CNT_WIDTH'(1);
        inst_cnt  <= inst_cnt + CNT_WIDTH'(inst_retire);
      end
    end
  end
endmodule

// File: doc/mmio_uart_ctrl.md
Name: mmio_uart_ctrl

Overview:
- Memory-mapped I/O responder that answers CPU load/store requests aimed at the I/O region (addr[31:28] == IO_TAG).
- Turns those requests into ready/valid handshakes with the on-chip UART, and exposes cycle and retired-instruction counters.
- Sits beside dmem/bios_mem. Requests come from the execute-stage ALU address and store data; read data returns one cycle later into writeback, matching the synchronous memory read latency.

Parameters:
IO_TAG, 4'h8, value of addr[31:28] that selects this block
CNT_WIDTH, 32, width of cycle and instruction counters (rdata zero-extends to 32)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low (asserted when 0)
addr  in  32  byte address of request (execute stage)
wdata  in  32  store data; only [7:0] used
we  in  1  store request this cycle (sw/sb/sh; byte lanes ignored)
re  in  1  load request this cycle
inst_retire  in  1  one pulse per retired instruction
rdata  out  32  load response, valid the cycle after re
tx_data  out  8  byte to UART transmitter
tx_valid  out  1  tx_data valid
tx_ready  in  1  UART transmitter accepts
rx_data  in  8  byte from UART receiver
rx_valid  in  1  rx_data valid
rx_ready  out  1  block accepts rx byte

Behaviour:
- Hit: sel = (addr[31:28] == IO_TAG). Register offset is addr[7:0]. Requests with sel = 0 are ignored, and the following rdata = 0.
- Register map:
  - 0x00 R: status = {30'b0, rx_full, ~tx_full}
  - 0x04 R: {24'b0, rx_buf}; a read pops the entry (rx_full <= 0)
  - 0x08 W: tx byte = wdata[7:0]
  - 0x10 R: cycle_cnt
  - 0x14 R: inst_cnt
  - 0x18 W: any write clears both counters
  - Other offsets: read 0, write ignored. Writes to read-only offsets are ignored; reads of write-only offsets return 0.
- Read timing:
  - rdata is registered. It reflects state sampled in the re cycle and is valid exactly one cycle later.
  - rdata = 0 in any cycle whose previous cycle had no selected read.
  - we and re together: both are serviced.
- TX path (one-entry buffer tx_buf / tx_full):
  - tx_valid = tx_full; tx_data = tx_buf.
  - Handshake completes when tx_valid & tx_ready; tx_full then clears next edge.
  - Write to 0x08 with tx_full = 0: latch byte, tx_full <= 1.
  - Write to 0x08 in the same cycle a handshake completes: new byte latched, tx_full stays 1.
  - Write to 0x08 with tx_full = 1 and no handshake: byte dropped, state unchanged.
- RX path (one-entry buffer rx_buf / rx_full):
  - rx_ready = ~rx_full (combinational).
  - rx_valid & rx_ready: latch rx_data, rx_full <= 1.
  - A pop read while full clears rx_full. A new byte can then be accepted from the next cycle; no bypass in the pop cycle.
  - Pop read while empty: returns stale rx_buf value, no state change.
- Counters:
  - cycle_cnt increments every non-reset cycle.
  - inst_cnt increments on inst_retire.
  - Both wrap modulo 2^CNT_WIDTH.
  - A write to 0x18 wins over increment in the same cycle; the counter is 0 on the next cycle.
- Reset (rst = 0 at posedge): rdata = 0, tx_valid = 0, tx_data = 0, tx_full = 0, rx_full = 0 (rx_ready = 1 afterwards), rx_buf = 0, both counters = 0.
  - Reset mid-handshake aborts: a pending tx byte is lost and a held rx byte is discarded.
  - Requests in the reset cycle are ignored.

Test Plan:
- Reset then read 0x8000_0000 -> next-cycle rdata = 32'h1 (tx not full, rx empty); tx_valid = 0, rx_ready = 1.
- Store 0x41 to 0x8000_0008 with tx_ready = 0 for 5 cycles -> tx_valid = 1, tx_data = 8'h41 held; status read = 0. Then tx_ready = 1 -> tx_valid drops next cycle and status = 1.
- Second store 0x42 while tx full and tx_ready = 0 -> dropped, tx_data stays 0x41. Repeat with store 0x43 in the handshake cycle -> tx_data = 0x43, tx_valid stays 1.
- Drive rx_valid with 0x5A -> rx_ready falls next cycle; status read = 32'h3. Load 0x8000_0004 -> rdata = 32'h5A and rx_ready = 1 the cycle after. Drive 0x5B in the pop cycle -> not accepted until rx_ready is high.
- Run 100 cycles with 37 inst_retire pulses after reset -> reads of 0x10 and 0x14 return the exact counts at sample time. Write 0x18 -> subsequent read of 0x14 = 0; force cycle_cnt near 2^32-1 and confirm wrap to 0.
- Load from 0x1000_0000 (sel = 0) and from 0x8000_0020 -> rdata = 0 next cycle, no UART side effects. Assert rst mid-TX -> tx_valid = 0 and counters 0 after the reset edge.
